// File: rtl/elastic_pipe.sv
// Elastic pipeline register: DEPTH valid/data stages with ready back-propagation,
// bubble collapsing, synchronous flush and a registered occupancy count.
module elastic_pipe #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  // Handshake: a beat moves on a rising edge only when valid and ready are both
  // high in that cycle; valid never waits on ready, and a stalled output holds
  // its payload until it is taken.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             ready_chain;
  logic             in_xfer;
  logic             out_xfer;

  // A stage advances when it is empty or when everything downstream advances.
  always_comb begin
    ready_chain = out_ready;
    adv         = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_chain = !v[k] | ready_chain;
      adv[k]      = ready_chain;
    end
  end

  always_comb begin
    src_v[0] = in_valid & !flush;
    src_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Data only loads when a real beat arrives, so an emptied output keeps
  // showing the last delivered payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) begin
            d[k] <= src_d[k];
          end
        end
      end
      if (flush) begin
        v     <= '0;
        count <= '0;
      end else begin
        count <= count + CW'(in_xfer) - CW'(out_xfer);
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: two instances (DEPTH 3 and 4) share stimulus; each has
// a scoreboard monitor, and the driver adds hand-computed directed checks.
module tb_elastic_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic [1:0]  rdy;
  logic [1:0]  ov;
  logic [15:0] od [2];
  logic [2:0]  cnt [2];

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard per instance
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D   = (g == 0) ? 3 : 4;
    localparam int CWL = $clog2(D + 1);
    logic [CWL-1:0] c;
    logic [15:0]    exp_q [$];
    int             cnt_m = 0;

    elastic_pipe #(.WIDTH(16), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_data   (in_data),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .count     (c)
    );
    assign cnt[g] = 3'(c);

    always @(negedge clk) begin
      if (reset) begin
        exp_q.delete();
        cnt_m = 0;
      end else begin
        check($sformatf("L%0d count", g), 32'(c), 32'(cnt_m));
        check($sformatf("L%0d in_ready", g), 32'(rdy[g]),
              32'(!flush && (cnt_m < D || out_ready)));
        if (ov[g]) begin
          check($sformatf("L%0d valid_has_beat", g), 32'(exp_q.size() > 0), 32'd1);
        end
        if (ov[g] && out_ready && exp_q.size() > 0) begin
          check($sformatf("L%0d data", g), 32'(od[g]), 32'(exp_q.pop_front()));
        end
        if (in_valid && rdy[g]) exp_q.push_back(in_data);
        if (flush) begin
          exp_q.delete();
          cnt_m = 0;
        end else begin
          cnt_m = cnt_m + int'(in_valid && rdy[g]) - int'(ov[g] && out_ready);
        end
      end
    end
  end

  // driver: apply one cycle of inputs, return at the following negedge
  task automatic drive(input logic rst, input logic v, input logic [15:0] dat,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (8) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  logic [15:0] bp_vals [5];

  initial begin
    bp_vals = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE};

    // reset with a beat offered: nothing captured
    drive(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check("rst out_valid", 32'(ov[g]), 32'd0);
      check("rst out_data", 32'(od[g]), 32'd0);
      check("rst count", 32'(cnt[g]), 32'd0);
      check("rst in_ready", 32'(rdy[g]), 32'd1);
    end

    // streaming 0x1..0x10 with out_ready high
    for (int j = 0; j < 22; j++) begin
      drive(1'b0, j < 16, 16'(j + 1), 1'b1, 1'b0);
      if (j >= 3 && j <= 18) begin
        check("stream3 valid", 32'(ov[0]), 32'd1);
        check("stream3 data", 32'(od[0]), 32'(j - 2));
      end else begin
        check("stream3 idle", 32'(ov[0]), 32'd0);
      end
      if (j >= 3 && j <= 16) check("stream3 count", 32'(cnt[0]), 32'd3);
      if (j >= 4 && j <= 19) check("stream4 data", 32'(od[1]), 32'(j - 3));
    end
    drain();

    // backpressure fill on DEPTH 4
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b1, bp_vals[j], 1'b0, 1'b0);
      check("fill in_ready", 32'(rdy[1]), 32'(j < 4));
    end
    check("fill count", 32'(cnt[1]), 32'd4);
    check("fill head", 32'(od[1]), 32'hA);
    drive(1'b0, 1'b1, 16'hE, 1'b0, 1'b0);
    check("fill stable", 32'(od[1]), 32'hA);
    check("fill valid", 32'(ov[1]), 32'd1);
    drive(1'b0, 1'b1, 16'hE, 1'b1, 1'b0);
    check("passthru ready", 32'(rdy[1]), 32'd1);
    check("passthru head", 32'(od[1]), 32'hA);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("passthru count", 32'(cnt[1]), 32'd4);
    for (int j = 1; j < 5; j++) begin
      if (j > 1) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check("release valid", 32'(ov[1]), 32'd1);
      check("release data", 32'(od[1]), 32'(bp_vals[j]));
    end
    drain();

    // bubble collapse: 0x5, two idle cycles, 0x6, output stalled
    drive(1'b0, 1'b1, 16'h5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h6, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check("bubble count", 32'(cnt[g]), 32'd2);
      check("bubble head", 32'(od[g]), 32'h5);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) check("bubble first", 32'(od[g]), 32'h5);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check("bubble second valid", 32'(ov[g]), 32'd1);
      check("bubble second", 32'(od[g]), 32'h6);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check("empty valid", 32'(ov[g]), 32'd0);
      check("empty last data", 32'(od[g]), 32'h6);
    end
    drain();

    // flush with three beats resident and a beat offered
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, 16'(16'h31 + j), 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("preflush count", 32'(cnt[1]), 32'd3);
    drive(1'b0, 1'b1, 16'h77, 1'b1, 1'b1);
    for (int g = 0; g < 2; g++) begin
      check("flush in_ready", 32'(rdy[g]), 32'd0);
      check("flush head", 32'(od[g]), 32'h31);
    end
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int g = 0; g < 2; g++) begin
        check("postflush valid", 32'(ov[g]), 32'd0);
        check("postflush count", 32'(cnt[g]), 32'd0);
      end
    end

    // random traffic with occasional flush
    for (int j = 0; j < 10000; j++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    // reset mid-stream
    drive(1'b1, 1'b1, 16'h55, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      check("midrst valid", 32'(ov[g]), 32'd0);
      check("midrst data", 32'(od[g]), 32'd0);
      check("midrst count", 32'(cnt[g]), 32'd0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
